// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg: controller state encoding and default widths/limits
package filter_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, READ, DRAIN, DONE} state_t;
  localparam int N_SAMPLES_D = 16384;
  localparam int ADDR_W_D = 14;
  localparam int DATA_W_D = 16;
  localparam int ACC_W_D = 105;
  localparam int OUT_SHIFT_D = 16;
  localparam int FLUSH_CYCLES_D = 8;
  localparam int DRAIN_TMO_D = 1024;
endpackage

// File: rtl/filter_ctrl_if.sv
// filter_ctrl_if: sample RAM, filter core and result bus seen by the controller
interface filter_ctrl_if import filter_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ACC_W = ACC_W_D
) ();
  logic ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic filt_rst;
  logic [DATA_W-1:0] filt_in;
  logic filt_in_vld;
  logic [ACC_W-1:0] filt_out;
  logic filt_out_vld;
  logic [DATA_W-1:0] res_data;
  logic res_vld;
  modport master (
    output ram_rd_en, ram_addr, filt_rst, filt_in, filt_in_vld, res_data, res_vld,
    input ram_data, filt_out, filt_out_vld
  );
  modport slave (
    input ram_rd_en, ram_addr, filt_rst, filt_in, filt_in_vld, res_data, res_vld,
    output ram_data, filt_out, filt_out_vld
  );
endinterface

// File: rtl/filter_ctrl_sat.sv
// filter_ctrl_sat: arithmetic right shift of the accumulator, saturated to DATA_W
module filter_ctrl_sat import filter_ctrl_pkg::*; #(
  parameter int ACC_W = ACC_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DATA_W-1:0] o_res
);
  logic [ACC_W-1:0] w_sh;
  logic [ACC_W-DATA_W:0] w_top;
  logic w_ovf;
  assign w_sh = ACC_W'($signed(i_acc) >>> OUT_SHIFT);
  assign w_top = w_sh[ACC_W-1:DATA_W-1];
  // in range only when every bit above the result is a copy of its sign bit
  assign w_ovf = !(&w_top || !(|w_top));
  assign o_res = w_ovf ? {w_top[ACC_W-DATA_W], {(DATA_W-1){!w_top[ACC_W-DATA_W]}}} : w_sh[DATA_W-1:0];
endmodule

// File: rtl/filter_controller.sv
// filter_controller: flush/read/drain sequencer feeding the FIR core; PEAK_TRACK_EN adds peak tracking
module filter_controller import filter_ctrl_pkg::*; #(
  parameter int N_SAMPLES = N_SAMPLES_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_D,
  parameter int DRAIN_TMO = DRAIN_TMO_D
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  filter_ctrl_if.master bus,
  output logic o_busy,
  output logic o_done,
  output logic o_err_tmo
`ifdef PEAK_TRACK_EN
  ,
  output logic [DATA_W-1:0] o_peak_abs,
  output logic [ADDR_W-1:0] o_peak_idx
`endif
);
  localparam int TMR_W = $clog2(DRAIN_TMO) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W:0] NCNT = (ADDR_W+1)'(N_SAMPLES);
  localparam logic [TMR_W-1:0] FL_END = TMR_W'(FLUSH_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_END = TMR_W'(DRAIN_TMO - 1);
  state_t r_state, w_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0] r_cnt;
  logic [DATA_W-1:0] r_res, w_sat;
  logic r_in_vld, r_res_vld, r_err, w_tmo, w_go, w_cnt_en;
  filter_ctrl_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W), .OUT_SHIFT(OUT_SHIFT)) u_sat (
    .i_acc(bus.filt_out),
    .o_res(w_sat)
  );
  always_comb begin
    w_nxt = r_state;
    w_tmo = 1'b0;
    case (r_state)
      IDLE, DONE: w_nxt = i_start ? FLUSH : r_state;
      FLUSH: w_nxt = (r_tmr == FL_END) ? READ : FLUSH;
      READ: w_nxt = (r_addr == LAST) ? DRAIN : READ;
      DRAIN: begin
        w_tmo = r_cnt < NCNT && !bus.filt_out_vld && r_tmr == TMO_END;
        w_nxt = (r_cnt >= NCNT || w_tmo) ? DONE : DRAIN;
      end
      default: w_nxt = FLUSH;
    endcase
  end
  assign w_go = w_nxt == FLUSH && r_state != FLUSH;
  assign w_cnt_en = bus.filt_out_vld && (r_state == READ || r_state == DRAIN);
  // r_tmr times the flush in FLUSH and the idle gap in DRAIN; it restarts on every state change
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= FLUSH;
      r_tmr <= '0;
      r_addr <= '0;
      r_cnt <= '0;
      r_in_vld <= 1'b0;
      r_res_vld <= 1'b0;
      r_res <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tmr <= (w_nxt != r_state || (r_state == DRAIN && bus.filt_out_vld)) ? '0 : r_tmr + TMR_W'(1);
      r_addr <= r_state == FLUSH ? '0 : (r_state == READ && r_addr != LAST) ? r_addr + ADDR_W'(1) : r_addr;
      r_cnt <= w_go ? '0 : r_cnt + (ADDR_W+1)'(w_cnt_en);
      r_in_vld <= bus.ram_rd_en;
      r_res_vld <= w_cnt_en;
      r_res <= w_cnt_en ? w_sat : r_res;
      r_err <= w_go ? 1'b0 : r_err | w_tmo;
    end
  assign bus.ram_rd_en = r_state == READ;
  assign bus.ram_addr = r_addr;
  assign bus.filt_rst = rst || r_state == FLUSH;
  assign bus.filt_in_vld = r_in_vld;
  assign bus.filt_in = r_in_vld ? bus.ram_data : '0;
  assign bus.res_data = r_res;
  assign bus.res_vld = r_res_vld;
  assign o_busy = !rst && (r_state == FLUSH || r_state == READ || r_state == DRAIN);
  assign o_done = r_state == DONE;
  assign o_err_tmo = r_err;
`ifdef PEAK_TRACK_EN
  logic [DATA_W-1:0] r_pk, w_abs;
  logic [ADDR_W-1:0] r_pk_idx;
  assign w_abs = !w_sat[DATA_W-1] ? w_sat :
                 (w_sat == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}} : -w_sat;
  // strict compare keeps the earliest index on ties
  always_ff @(posedge clk)
    if (rst || w_go) begin
      r_pk <= '0;
      r_pk_idx <= '0;
    end else if (w_cnt_en && w_abs > r_pk) begin
      r_pk <= w_abs;
      r_pk_idx <= r_cnt[ADDR_W-1:0];
    end
  assign o_peak_abs = r_pk;
  assign o_peak_idx = r_pk_idx;
`endif
endmodule

// File: tb/tb_filter_controller.sv
// tb_filter_controller: randomized runs against a RAM/filter model and an arithmetic reference
module tb_filter_controller;
  localparam int N = 16;
  localparam int TMO = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, err;
`ifdef PEAK_TRACK_EN
  logic [15:0] pk_abs;
  logic [13:0] pk_idx;
`endif
  int n_chk = 0;
  int n_err = 0;
  logic [15:0] ram [N];
  longint tbl [N];
  longint got [N];
  longint K = 65536;
  int drop = 0;
  bit sat_mode = 1'b0;
  longint pv [3];
  bit pvld [3];
  int jin = 0;
  always #5 clk = ~clk;
  filter_ctrl_if bus ();
  filter_controller #(.N_SAMPLES(N)) dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .bus(bus),
    .o_busy(busy),
    .o_done(done),
    .o_err_tmo(err)
`ifdef PEAK_TRACK_EN
    ,
    .o_peak_abs(pk_abs),
    .o_peak_idx(pk_idx)
`endif
  );
  always @(posedge clk) if (bus.ram_rd_en) bus.ram_data <= ram[bus.ram_addr[3:0]];
  always @(posedge clk)
    if (bus.filt_rst) begin
      pvld[0] <= 1'b0;
      pvld[1] <= 1'b0;
      pvld[2] <= 1'b0;
      jin <= 0;
    end else begin
      pvld[0] <= bus.filt_in_vld && jin < N - drop;
      pv[0] <= sat_mode ? tbl[jin % N] : longint'($signed(bus.filt_in)) * K;
      jin <= jin + int'(bus.filt_in_vld);
      pvld[1] <= pvld[0];
      pvld[2] <= pvld[1];
      pv[1] <= pv[0];
      pv[2] <= pv[1];
    end
  assign bus.filt_out = {{41{pv[2][63]}}, pv[2]};
  assign bus.filt_out_vld = pvld[2];
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic longint sat16(input longint v);
    longint s = v >>> 16;
    return s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
  endfunction
  function automatic longint ref_res(input int i);
    return sat16(sat_mode ? tbl[i] : longint'($signed(ram[i])) * K);
  endfunction
  task automatic run_chk(input string tg, input bit exp_tmo);
    int fl = 0, rd = 0, vin = 0, nres = 0, b_addr = 0, b_in = 0, b_res = 0, cyc, prv_addr = 0;
    bit prv_rd = 1'b0;
    longint e, a, pk_e = 0;
    int pki_e = 0;
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (bus.filt_rst) fl++;
      if (bus.filt_in_vld) begin
        vin++;
        if (!prv_rd || bus.filt_in !== ram[prv_addr]) b_in++;
      end
      if (bus.ram_rd_en) begin
        if (int'(bus.ram_addr) != rd) b_addr++;
        rd++;
      end
      if (bus.res_vld) begin
        e = ref_res(nres % N);
        got[nres % N] = longint'($signed(bus.res_data));
        if (got[nres % N] != e) b_res++;
        a = e < 0 ? (e == -32768 ? 32767 : -e) : e;
        if (a > pk_e) begin
          pk_e = a;
          pki_e = nres;
        end
        nres++;
      end
      prv_rd = bus.ram_rd_en;
      prv_addr = int'(bus.ram_addr[3:0]);
    end
    chk({tg, "_done"}, done, 1);
    chk({tg, "_flush_cycles"}, fl, 8);
    chk({tg, "_reads"}, rd, N);
    chk({tg, "_addr_order"}, b_addr, 0);
    chk({tg, "_in_vld"}, vin, N);
    chk({tg, "_in_data"}, b_in, 0);
    chk({tg, "_results"}, nres, N - drop);
    chk({tg, "_res_data"}, b_res, 0);
    chk({tg, "_err_tmo"}, err, exp_tmo);
    chk({tg, "_busy"}, busy, 0);
    chk({tg, "_waited_tmo"}, cyc > TMO, exp_tmo);
`ifdef PEAK_TRACK_EN
    chk({tg, "_peak_abs"}, pk_abs, pk_e);
    chk({tg, "_peak_idx"}, pk_idx, pki_e);
`endif
  endtask
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_err_clr", err, 0);
`ifdef PEAK_TRACK_EN
    chk("start_peak_clr", pk_abs, 0);
    chk("start_peak_idx_clr", pk_idx, 0);
`endif
  endtask
  task automatic rand_ram();
    for (int i = 0; i < N; i++) ram[i] = 16'($urandom);
    case ($urandom_range(0, 3))
      0: K = 65536;
      1: K = longint'(1) <<< 20;
      2: K = longint'($urandom_range(1, 1 << 24));
      default: K = longint'($urandom_range(1, 65535));
    endcase
  endtask
  initial begin
    int c;
    for (int i = 0; i < N; i++) ram[i] = 16'(i - 8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_filt_rst", bus.filt_rst, 1);
    chk("rst_rd_en", bus.ram_rd_en, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_in_vld", bus.filt_in_vld, 0);
    chk("rst_res_vld", bus.res_vld, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_chk("echo", 1'b0);
    chk("echo_first", got[0], -8);
    chk("echo_last", got[N-1], 7);
    sat_mode = 1'b1;
    tbl[0] = longint'(1) <<< 40;
    tbl[1] = -(longint'(1) <<< 40);
    tbl[2] = longint'(5) <<< 16;
    tbl[3] = -1;
    tbl[4] = (longint'(32767) <<< 16) + 65535;
    tbl[5] = longint'(32768) <<< 16;
    tbl[6] = longint'(-32769) <<< 16;
    tbl[7] = longint'(-32768) <<< 16;
    for (int i = 8; i < N; i++) tbl[i] = longint'($signed({$urandom, $urandom})) >>> 28;
    pulse_start();
    run_chk("sat", 1'b0);
    chk("sat_pos", got[0], 32767);
    chk("sat_neg", got[1], -32768);
    chk("sat_five", got[2], 5);
    chk("sat_minus1", got[3], -1);
    sat_mode = 1'b0;
    for (int r = 0; r < 4; r++) begin
      rand_ram();
      pulse_start();
      run_chk($sformatf("rand%0d", r), 1'b0);
    end
    drop = 2;
    rand_ram();
    pulse_start();
    run_chk("tmo", 1'b1);
    drop = 0;
    pulse_start();
    run_chk("after_tmo", 1'b0);
    rand_ram();
    pulse_start();
    for (c = 0; c < 100 && !(bus.ram_rd_en && bus.ram_addr == 3); c++) @(negedge clk);
    chk("reach_addr3", c < 100, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_read_addr", bus.ram_addr, 4);
    chk("start_in_read_rd", bus.ram_rd_en, 1);
    repeat (3) @(negedge clk);
    chk("abort_at_addr7", bus.ram_addr, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rd_en", bus.ram_rd_en, 0);
    chk("abort_in_vld", bus.filt_in_vld, 0);
    chk("abort_res_vld", bus.res_vld, 0);
    chk("abort_res_data", bus.res_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_filt_rst", bus.filt_rst, 1);
    chk("abort_addr", bus.ram_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_chk("restart", 1'b0);
`ifdef PEAK_TRACK_EN
    for (int i = 0; i < N; i++) ram[i] = 16'(0);
    ram[0] = 16'(3);
    ram[1] = 16'(-9);
    ram[2] = 16'(9);
    ram[3] = 16'(2);
    K = 65536;
    pulse_start();
    run_chk("peak", 1'b0);
    chk("peak_fixed_abs", pk_abs, 9);
    chk("peak_fixed_idx", pk_idx, 1);
    pulse_start();
    run_chk("peak_rerun", 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
